// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reads back a multiplexed 7-segment bus and decodes each digit
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   an           in   [N_DIGITS-1:0] anode strobes, bit i selects digit i
//   seg          in   [6:0] active-low segments, seg[6]=CA ... seg[0]=CG
//   digits       out  [4*N_DIGITS-1:0] decoded nibble of digit i at [4i+3:4i]
//   digit_err    out  [N_DIGITS-1:0] last capture of digit i was an illegal pattern
//   frame_valid  out  one-cycle pulse once every digit has been captured
//   scan_err     out  one-cycle pulse after a registered sample with >1 anode asserted
module seg7_scan_decoder #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [6:0]            seg,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_err,
    output logic                  frame_valid,
    output logic                  scan_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURED
    } state_t;

    state_t                state_q, state_d;
    logic [N_DIGITS-1:0]   r_an_q, r_an_d;
    logic [6:0]            r_seg_q, r_seg_d;
    logic [N_DIGITS-1:0]   p_an_q, p_an_d;
    logic [6:0]            p_seg_q, p_seg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  scan_err_q, scan_err_d;

    logic [N_DIGITS-1:0]   an_norm;
    logic                  an_one_hot;
    logic                  an_multi;
    logic                  pair_changed;
    logic                  capture;
    logic [3:0]            dec_nib;
    logic                  dec_err;

    assign an_norm = AN_ACTIVE_LOW ? ~an : an;

    // Segment pattern (active-low, CA..CG) back to a BCD nibble.
    always_comb begin
        dec_nib = 4'hE;
        dec_err = 1'b0;
        case (r_seg_q)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b1111111: dec_nib = 4'hF;
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        r_an_d  = an_norm;
        r_seg_d = seg;
        p_an_d  = r_an_q;
        p_seg_d = r_seg_q;

        // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
        an_one_hot   = (r_an_q != '0) && ((r_an_q & (r_an_q - N_DIGITS'(1))) == '0);
        an_multi     = (r_an_q != '0) && !an_one_hot;
        pair_changed = (r_an_q != p_an_q) || (r_seg_q != p_seg_q);

        if (pair_changed || !an_one_hot) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (an_one_hot) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!an_one_hot) begin
                    state_d = S_IDLE;
                end else if (!pair_changed && (cnt_q == CNT_CAP)) begin
                    capture = 1'b1;
                    state_d = S_CAPTURED;
                end
            end
            S_CAPTURED: begin
                if (pair_changed) begin
                    state_d = an_one_hot ? S_SETTLE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completed frame is reported one edge after the completing write; a write on
        // that same edge belongs to the next frame.
        frame_valid_d = &seen_q;
        seen_d        = frame_valid_d ? '0 : seen_q;
        digits_d      = digits_q;
        digit_err_d   = digit_err_q;
        if (capture) begin
            seen_d = seen_d | r_an_q;
            for (int i = 0; i < N_DIGITS; i++) begin
                if (r_an_q[i]) begin
                    digits_d[4*i +: 4] = dec_nib;
                    digit_err_d[i]     = dec_err;
                end
            end
        end

        scan_err_d = an_multi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            r_an_q        <= '0;
            r_seg_q       <= '0;
            p_an_q        <= '0;
            p_seg_q       <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            digits_q      <= '1;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_an_q        <= r_an_d;
            r_seg_q       <= r_seg_d;
            p_an_q        <= p_an_d;
            p_seg_q       <= p_seg_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign scan_err    = scan_err_q;

endmodule
